// File: rtl/ide_pkg.sv
// Shared ATA/IDE definitions: register addresses, status bits, command codes, PIO FSM states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ide_pkg;

    // Register addresses as {CS1-,CS0-,DA[2:0]}
    localparam logic [4:0] ADDR_DATA      = 5'b10000;
    localparam logic [4:0] ADDR_ERROR     = 5'b10001;  // ERROR on read, FEATURE on write
    localparam logic [4:0] ADDR_SECCNT    = 5'b10010;
    localparam logic [4:0] ADDR_SECNUM    = 5'b10011;
    localparam logic [4:0] ADDR_CYLLOW    = 5'b10100;
    localparam logic [4:0] ADDR_CYLHIGH   = 5'b10101;
    localparam logic [4:0] ADDR_DRVHEAD   = 5'b10110;
    localparam logic [4:0] ADDR_STATUS    = 5'b10111;  // STATUS on read, COMMAND on write
    localparam logic [4:0] ADDR_ALTSTATUS = 5'b01110;  // ALTSTATUS on read, DEVCTRL on write

    // STATUS register bit positions
    localparam int STAT_BSY  = 7;
    localparam int STAT_DRDY = 6;
    localparam int STAT_DRQ  = 3;
    localparam int STAT_ERR  = 0;

    // Command codes
    localparam logic [15:0] CMD_READ  = 16'h0020;
    localparam logic [15:0] CMD_WRITE = 16'h0030;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } ide_state_t;

    function automatic logic [15:0] byte_swap(input logic [15:0] d);
        return {d[7:0], d[15:8]};
    endfunction

endpackage

// File: rtl/ide_pio.sv
// PIO-mode-0 register access engine: one timed DIOR-/DIOW- bus cycle per client request.
// Latency: ata_done pulses in the cycle after edge k+T_SETUP+T_PULSE+T_HOLD+1 (request sampled at edge k).
// Backpressure: level requests are only sampled in IDLE; optional IDE_DATA_SWAP_EN byte-swaps DATA accesses.
module ide_pio
    import ide_pkg::*;
#(
    parameter int T_SETUP = 4,
    parameter int T_PULSE = 9,
    parameter int T_HOLD  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ata_rd,
    input  logic        ata_wr,
    input  logic [4:0]  ata_addr,
    input  logic [15:0] ata_in,
    output logic [15:0] ata_out,
    output logic        ata_done,
    input  logic [15:0] ide_data_in,
    output logic [15:0] ide_data_out,
    output logic        ide_dior,
    output logic        ide_diow,
    output logic [1:0]  ide_cs,
    output logic [2:0]  ide_da
);

    // Counter reload values: each phase counts down to zero, so load length-1
    localparam logic [7:0] C_SETUP = 8'(T_SETUP - 1);
    localparam logic [7:0] C_PULSE = 8'(T_PULSE - 1);
    localparam logic [7:0] C_HOLD  = 8'(T_HOLD - 1);

    ide_state_t  r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        w_cnt_zero;
    logic        w_start;
    logic        w_capture;
    logic        r_wr;
    logic [1:0]  r_cs;
    logic [2:0]  r_da;
    logic [15:0] r_dout;
    logic [15:0] r_out;
    logic        r_done;
    logic        w_swap_wr;
    logic        w_swap_rd;
    logic [15:0] w_wr_data;
    logic [15:0] w_rd_data;

`ifdef IDE_DATA_SWAP_EN
    // Write swap follows the live address at the sample; read swap follows the latched address
    assign w_swap_wr = (ata_addr == ADDR_DATA);
    assign w_swap_rd = ({r_cs, r_da} == ADDR_DATA);
`else
    assign w_swap_wr = 1'b0;
    assign w_swap_rd = 1'b0;
`endif

    assign w_wr_data  = w_swap_wr ? byte_swap(ata_in) : ata_in;
    assign w_rd_data  = w_swap_rd ? byte_swap(ide_data_in) : ide_data_in;
    assign w_cnt_zero = (r_cnt == 8'd0);

    // Next-state and phase counter; write wins over read when both are requested
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ata_wr || ata_rd) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = C_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = C_PULSE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_STROBE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = C_HOLD;
                    w_capture   = ~r_wr;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Bus-side latches: address/direction/write data at the sample, read data at the last strobe edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr   <= 1'b0;
            r_cs   <= 2'b11;
            r_da   <= 3'd0;
            r_dout <= 16'd0;
            r_out  <= 16'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            if (w_start) begin
                r_cs <= ata_addr[4:3];
                r_da <= ata_addr[2:0];
                r_wr <= ata_wr;
                if (ata_wr) begin
                    r_dout <= w_wr_data;
                end
            end
            if (w_capture) begin
                r_out <= w_rd_data;
            end
            if (r_state == ST_DONE) begin
                r_cs <= 2'b11;
            end
        end
    end

    assign ide_dior     = ~((r_state == ST_STROBE) && !r_wr);
    assign ide_diow     = ~((r_state == ST_STROBE) && r_wr);
    assign ide_cs       = r_cs;
    assign ide_da       = r_da;
    assign ide_data_out = r_dout;
    assign ata_out      = r_out;
    assign ata_done     = r_done;

endmodule

// File: tb/tb_ide_pio.sv
// Randomized self-checking bench for ide_pio against a transaction-level reference model.
// Latency: each access is expected to finish 16 cycles after its sample edge.
// Backpressure: requests are dropped right after the sample edge except in the polling test.
module tb_ide_pio;
    import ide_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ata_rd;
    logic        ata_wr;
    logic [4:0]  ata_addr;
    logic [15:0] ata_in;
    logic [15:0] ata_out;
    logic        ata_done;
    logic [15:0] ide_data_in;
    logic [15:0] ide_data_out;
    logic        ide_dior;
    logic        ide_diow;
    logic [1:0]  ide_cs;
    logic [2:0]  ide_da;

    logic [15:0] drv_val;
    int          checks = 0;
    int          errors = 0;

    // Reference state: what ata_out and ide_data_out should hold between accesses
    logic [15:0] exp_out  = 16'd0;
    logic [15:0] exp_dout = 16'd0;

    localparam int LAT = 16;   // T_SETUP + T_PULSE + T_HOLD + 1
    localparam int PW  = 9;    // T_PULSE

    ide_pio dut (
        .clk          (clk),
        .reset        (reset),
        .ata_rd       (ata_rd),
        .ata_wr       (ata_wr),
        .ata_addr     (ata_addr),
        .ata_in       (ata_in),
        .ata_out      (ata_out),
        .ata_done     (ata_done),
        .ide_data_in  (ide_data_in),
        .ide_data_out (ide_data_out),
        .ide_dior     (ide_dior),
        .ide_diow     (ide_diow),
        .ide_cs       (ide_cs),
        .ide_da       (ide_da)
    );

    always #5 clk = ~clk;

    // Drive model: presents its data only while DIOR- is low, junk otherwise
    assign ide_data_in = ide_dior ? 16'hBAD0 : drv_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [4:0] a, input logic [15:0] v);
`ifdef IDE_DATA_SWAP_EN
        if (a == 5'b10000) return {v[7:0], v[15:8]};
`endif
        return v;
    endfunction

    function automatic logic [15:0] model_wr(input logic [4:0] a, input logic [15:0] v);
`ifdef IDE_DATA_SWAP_EN
        if (a == 5'b10000) return {v[7:0], v[15:8]};
`endif
        return v;
    endfunction

    // One complete access with timing, strobe-width, address and data checks
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [4:0] addr, input logic [15:0] din,
                              input logic [15:0] dval, input bit scramble);
        int dior_n = 0;
        int diow_n = 0;
        int done_n = 0;
        int done_c = 0;
        int dout_bad = 0;
        logic [1:0] cs_s = 2'b00;
        logic [2:0] da_s = 3'd0;
        logic [1:0] cs_after = 2'b00;
        @(negedge clk);
        ata_rd = rd; ata_wr = wr; ata_addr = addr; ata_in = din; drv_val = dval;
        if (wr) exp_dout = model_wr(addr, din);
        else    exp_out  = model_rd(addr, dval);
        @(posedge clk);
        #1;
        ata_rd = 1'b0; ata_wr = 1'b0;
        if (scramble) begin
            ata_addr = 5'($urandom);
            ata_in   = 16'($urandom);
        end
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (!ide_dior) dior_n++;
            if (!ide_diow) diow_n++;
            if (c == 10) begin cs_s = ide_cs; da_s = ide_da; end
            if (c <= LAT && wr && ide_data_out !== exp_dout) dout_bad++;
            if (ata_done) begin done_n++; done_c = c; end
            if (c == LAT + 2) cs_after = ide_cs;
        end
        chk({tag, "_done_cnt"}, done_n, 1);
        chk({tag, "_done_cyc"}, done_c, LAT + 1);
        chk({tag, "_dior_w"}, dior_n, wr ? 0 : PW);
        chk({tag, "_diow_w"}, diow_n, wr ? PW : 0);
        chk({tag, "_cs"}, cs_s, addr[4:3]);
        chk({tag, "_da"}, da_s, addr[2:0]);
        chk({tag, "_dout_stable"}, dout_bad, 0);
        chk({tag, "_cs_idle"}, cs_after, 2'b11);
        chk({tag, "_dout"}, ide_data_out, exp_dout);
        chk({tag, "_out"}, ata_out, exp_out);
    endtask

    initial begin
        reset = 1'b1; ata_rd = 1'b0; ata_wr = 1'b0; ata_addr = 5'd0; ata_in = 16'd0;
        drv_val = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dior", ide_dior, 1'b1);
        chk("rst_diow", ide_diow, 1'b1);
        chk("rst_cs", ide_cs, 2'b11);
        chk("rst_da", ide_da, 3'd0);
        chk("rst_dout", ide_data_out, 16'd0);
        chk("rst_out", ata_out, 16'd0);
        chk("rst_done", ata_done, 1'b0);
        reset = 1'b0;

        // Directed accesses
        run_access("rd_status", 1'b1, 1'b0, 5'b10111, 16'h0000, 16'h0050, 1'b0);
        run_access("wr_drvhead", 1'b0, 1'b1, 5'b10110, 16'h0040, 16'h7777, 1'b0);
        run_access("rd_wr_both", 1'b1, 1'b1, 5'b10111, 16'h0020, 16'h5555, 1'b0);
        run_access("rd_data", 1'b1, 1'b0, 5'b10000, 16'h0000, 16'h1234, 1'b0);
        run_access("rd_status2", 1'b1, 1'b0, 5'b10111, 16'h0000, 16'h1234, 1'b0);
        run_access("wr_data", 1'b0, 1'b1, 5'b10000, 16'hABCD, 16'h0000, 1'b1);
        run_access("rd_alt", 1'b1, 1'b0, 5'b01110, 16'h0000, 16'h00D0, 1'b1);

        // Randomized accesses with mid-cycle address/data scrambling
        for (int i = 0; i < 10; i++) begin
            logic rd, wr;
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            run_access("rand", rd, wr, 5'($urandom), 16'($urandom), 16'($urandom), 1'b1);
        end

        // Continuous status polling: request held across three accesses
        begin
            logic [15:0] vals [3];
            int done_c [3];
            int nd = 0;
            int dior_n = 0;
            vals[0] = 16'h0080; vals[1] = 16'h0080; vals[2] = 16'h0050;
            @(negedge clk);
            drv_val = vals[0]; ata_addr = 5'b10111; ata_rd = 1'b1;
            @(posedge clk);
            for (int c = 1; c <= 80; c++) begin
                @(negedge clk);
                if (!ide_dior) dior_n++;
                if (ata_done) begin
                    if (nd < 3) done_c[nd] = c;
                    nd++;
                    if (nd < 3) drv_val = vals[nd];
                    else ata_rd = 1'b0;
                end
            end
            ata_rd = 1'b0;
            exp_out = model_rd(5'b10111, 16'h0050);
            chk("poll_done_cnt", nd, 3);
            chk("poll_first", done_c[0], LAT + 1);
            chk("poll_gap1", (done_c[1] - done_c[0]) >= 2, 1'b1);
            chk("poll_gap2", (done_c[2] - done_c[1]) >= 2, 1'b1);
            chk("poll_dior_w", dior_n, 3 * PW);
            chk("poll_out", ata_out, exp_out);
        end

        // Reset asserted in the middle of the read strobe
        begin
            int done_n = 0;
            int dior_n = 0;
            @(negedge clk);
            ata_rd = 1'b1; ata_addr = 5'b10111; drv_val = 16'h00FF;
            @(posedge clk);
            #1 ata_rd = 1'b0;
            repeat (8) @(negedge clk);
            chk("mid_in_strobe", ide_dior, 1'b0);
            reset = 1'b1;
            @(posedge clk);
            #1;
            chk("mid_rst_dior", ide_dior, 1'b1);
            chk("mid_rst_cs", ide_cs, 2'b11);
            chk("mid_rst_done", ata_done, 1'b0);
            chk("mid_rst_out", ata_out, 16'd0);
            reset = 1'b0;
            for (int c = 0; c < 25; c++) begin
                @(negedge clk);
                if (ata_done) done_n++;
                if (!ide_dior) dior_n++;
            end
            chk("mid_no_done", done_n, 0);
            chk("mid_no_strobe", dior_n, 0);
            chk("mid_out_kept", ata_out, 16'd0);
            exp_out = 16'd0;
            exp_dout = 16'd0;
        end

        // Swap behaviour is modelled by model_rd, so this holds in either build
        run_access("post_rst_rd", 1'b1, 1'b0, 5'b10000, 16'h0000, 16'h1234, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
